// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
//   fetch_state_t : fetch FSM states (REQ -> WAIT -> HOLD)
//   OP_*          : primary opcode field values, instr[31:26]
//   RESET_PC_DEFAULT : PC value taken on reset unless overridden
package mips_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection, purely combinational.
//   pc_cur       : PC of the instruction being retired
//   instr        : that instruction word
//   jump         : J resolved for this instruction (wins over branch)
//   branch_taken : Branch && zero for this instruction
//   next_pc      : jump target, branch target or pc_cur + 4
// All arithmetic wraps modulo 2^32; targets are word aligned by construction.
module next_pc_sel (
    input  logic [31:0] pc_cur,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        branch_taken,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] branch_off;
    logic [31:0] jump_target;

    assign pc4         = pc_cur + 32'd4;
    // Sign-extended word offset: imm16 shifted left by two.
    assign branch_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
    // Jump stays inside the 256 MB region of the delay-slot address.
    assign jump_target = {pc4[31:28], instr[25:0], 2'b00};

    always_comb begin
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = pc4 + branch_off;
        end else begin
            next_pc = pc4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word at a time over
// a req/ack handshake and presents it to decode with valid/ready.
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_req/addr     : fetch request and word address (addr == PC)
//   imem_rdata/ack    : instruction word and its one-cycle strobe
//   instr/opcode      : IR contents and its opcode field
//   pc_out            : PC of the instruction held in IR
//   instr_valid/ready : IR handshake towards decode
//   branch_taken/jump : resolved control flow, used only on the consume cycle
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic              jump
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              load_ir;
    logic              consume;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        load_ir    = 1'b0;
        consume    = 1'b0;
        case (state)
            REQ:  state_next = WAIT;
            WAIT: begin
                if (imem_ack) begin
                    load_ir    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    consume    = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // Decoded straight from the state register, so a reset during WAIT drops
    // the request in the same cycle and an ack outside WAIT is never seen.
    assign imem_req    = (state == WAIT);
    assign instr_valid = (state == HOLD);
    assign imem_addr   = pc;

    next_pc_sel u_next_pc_sel (
        .pc_cur       (pc_out),
        .instr        (instr),
        .jump         (jump),
        .branch_taken (branch_taken),
        .next_pc      (next_pc)
    );

    // NOTE: IR and pc_out are reset explicitly so decode never sees X after
    // reset, even though instr_valid already qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            instr  <= 32'h0;
            pc_out <= '0;
        end else begin
            if (load_ir) begin
                instr  <= imem_rdata;
                pc_out <= pc;
            end
            if (consume) begin
                pc <= next_pc;
            end
        end
    end

    assign opcode = instr[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic        jump;

    int passed = 0;
    int total  = 0;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .instr        (instr),
        .opcode       (opcode),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .jump         (jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;   // word returned by memory
        logic        jmp;     // jump on consume
        logic        br;      // branch_taken on consume
        logic [31:0] addr;    // expected fetch address
        logic [31:0] nxt;     // expected next fetch address
        int          delay;   // cycles in WAIT before ack
        int          hold;    // cycles of backpressure in HOLD
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("req_timeout", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        vec_t v;
        logic [31:0] ir_exp;

        vecs[0]  = '{32'h8C08_0004, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 0, 0};
        vecs[1]  = '{32'h0800_0004, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0010, 3, 0};
        vecs[2]  = '{32'h1000_FFFE, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_000C, 0, 0};
        vecs[3]  = '{32'h0800_0004, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0010, 1, 0};
        vecs[4]  = '{32'h1000_FFFE, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0014, 0, 5};
        vecs[5]  = '{32'h1000_FFFE, 1'b0, 1'b1, 32'h0000_0014, 32'h0000_0010, 0, 0};
        vecs[6]  = '{32'h0800_0040, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0100, 0, 2};
        vecs[7]  = '{32'h1000_0003, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0110, 0, 0};
        vecs[8]  = '{32'h1000_8000, 1'b0, 1'b1, 32'h0000_0110, 32'hFFFE_0114, 0, 0};
        vecs[9]  = '{32'h0BFF_FFF0, 1'b1, 1'b0, 32'hFFFE_0114, 32'hFFFF_FFC0, 0, 0};
        vecs[10] = '{32'h1000_0017, 1'b0, 1'b1, 32'hFFFF_FFC0, 32'h0000_0020, 0, 0};

        rst_n        = 1'b0;
        imem_rdata   = 32'h0;
        imem_ack     = 1'b0;
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",    {31'b0, imem_req}, 32'd0);
        check("rst_valid",  {31'b0, instr_valid}, 32'd0);
        check("rst_instr",  instr, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_addr",   imem_addr, 32'h0);
        rst_n = 1'b1;
        #1;
        check("req_low_before_first_edge", {31'b0, imem_req}, 32'd0);
        tick();
        check("first_req_cycle1", {31'b0, imem_req}, 32'd1);

        // Table-driven fetch / consume sequence
        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            wait_req();
            check($sformatf("v%0d_addr", i), imem_addr, v.addr);
            for (int d = 0; d < v.delay; d++) begin
                tick();
                check($sformatf("v%0d_wait_req", i), {31'b0, imem_req}, 32'd1);
                check($sformatf("v%0d_wait_addr", i), imem_addr, v.addr);
                check($sformatf("v%0d_wait_valid", i), {31'b0, instr_valid}, 32'd0);
            end
            imem_ack   = 1'b1;
            imem_rdata = v.rdata;
            #1;
            check($sformatf("v%0d_valid_before_edge", i), {31'b0, instr_valid}, 32'd0);
            tick();
            imem_ack   = 1'b0;
            imem_rdata = 32'h1234_5678;
            check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, 32'd1);
            check($sformatf("v%0d_instr", i), instr, v.rdata);
            check($sformatf("v%0d_opcode", i), {26'b0, opcode}, {26'b0, v.rdata[31:26]});
            check($sformatf("v%0d_pc_out", i), pc_out, v.addr);
            check($sformatf("v%0d_req_drop", i), {31'b0, imem_req}, 32'd0);
            // Backpressure: stray ack plus control inputs that must be ignored
            for (int h = 0; h < v.hold; h++) begin
                jump         = 1'b1;
                branch_taken = 1'b1;
                if (h == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = 32'hDEAD_BEEF;
                end
                tick();
                imem_ack = 1'b0;
                check($sformatf("v%0d_hold_instr", i), instr, v.rdata);
                check($sformatf("v%0d_hold_pc_out", i), pc_out, v.addr);
                check($sformatf("v%0d_hold_valid", i), {31'b0, instr_valid}, 32'd1);
                check($sformatf("v%0d_hold_req", i), {31'b0, imem_req}, 32'd0);
            end
            instr_ready  = 1'b1;
            jump         = v.jmp;
            branch_taken = v.br;
            tick();
            instr_ready  = 1'b0;
            jump         = 1'b0;
            branch_taken = 1'b0;
            check($sformatf("v%0d_consumed", i), {31'b0, instr_valid}, 32'd0);
            check($sformatf("v%0d_req_gap", i), {31'b0, imem_req}, 32'd0);
            check($sformatf("v%0d_next", i), imem_addr, v.nxt);
        end

        // Reset asserted mid-WAIT at pc 0x20
        wait_req();
        check("mid_wait_addr", imem_addr, 32'h0000_0020);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_wait_rst_req",   {31'b0, imem_req}, 32'd0);
        check("mid_wait_rst_valid", {31'b0, instr_valid}, 32'd0);
        check("mid_wait_rst_addr",  imem_addr, 32'h0);
        ir_exp = 32'h0;
        check("mid_wait_rst_instr", instr, ir_exp);
        tick();
        rst_n = 1'b1;
        // Late ack right after reset release: state is REQ, must be ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        check("late_ack_req",   {31'b0, imem_req}, 32'd1);
        check("late_ack_addr",  imem_addr, 32'h0);
        check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        check("late_ack_instr", instr, ir_exp);
        tick();
        check("late_ack_still_waiting", {31'b0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2408_0001;
        tick();
        imem_ack = 1'b0;
        check("post_rst_valid",  {31'b0, instr_valid}, 32'd1);
        check("post_rst_instr",  instr, 32'h2408_0001);
        check("post_rst_opcode", {26'b0, opcode}, 32'h0000_0009);
        check("post_rst_pc_out", pc_out, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", passed, total + 1);
        $finish;
    end

endmodule
